// File: rtl/avalon_ram_model.sv
// Avalon-MM slave memory model: DEPTH 32-bit words mapped at BASE_ADDR.
// Each transfer is stalled by a registered IDLE/BUSY/ACK FSM for a
// programmable number of wait states. Writes are byte-lane masked.
// Out-of-window accesses pulse range_err, and read+write together pulses
// protocol_err.
// Optional build macro RANDOM_WAIT_EN: the wait-state count is drawn from an
// 8-bit LFSR (taps 8,6,5,4, seed 8'hA5) instead of the fixed WAIT_CYCLES.
module avalon_ram_model #(
  parameter int unsigned DEPTH         = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
  parameter int unsigned WAIT_CYCLES   = 2,
  parameter string       RAM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        range_err,
  output logic        protocol_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        op_write_q;
  logic [31:0] readdata_q;
  logic        range_err_q;
  logic        protocol_err_q;
  logic [31:0] mem_q [DEPTH];

  logic        accept;
  logic        finish;
  logic [31:0] offset;
  logic [29:0] word_idx;
  logic        in_range;
  logic [AW-1:0] mem_idx;
  logic [3:0]  load_val;
  logic        unused_offset_bits;

  // Power-up contents: all zero.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem_q[i] = '0;
  end

  // Decode the captured address; an address below the base underflows to a
  // huge index, so it can never alias into the window.
  assign accept   = (state_q == IDLE) && (read || write);
  assign finish   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign offset   = addr_q - BASE_ADDR;
  assign word_idx = offset[31:2];
  assign in_range = (addr_q >= BASE_ADDR) && ({2'b00, word_idx} < DEPTH);
  assign mem_idx  = word_idx[AW-1:0];
  assign unused_offset_bits = ^offset[1:0];

`ifdef RANDOM_WAIT_EN
  logic [7:0] lfsr_q;

  // LFSR steps once per accepted request so the wait pattern repeats after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 8'hA5;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign load_val = 4'(lfsr_q[3:0] % (WAIT_CYCLES + 1));
`else
  assign load_val = 4'(WAIT_CYCLES);
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (read || write) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: stall whenever not acknowledging; in IDLE the stall is raised
  // combinationally so the master never sees a zero-wait completion.
  always_comb begin
    waitrequest = 1'b1;
    unique case (state_q)
      IDLE:    waitrequest = read | write;
      BUSY:    waitrequest = 1'b1;
      ACK:     waitrequest = 1'b0;
      default: waitrequest = 1'b1;
    endcase
  end

  // Request capture, wait counter, read data and error pulses. Only the
  // captured copies are used after acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      op_write_q     <= 1'b0;
      readdata_q     <= '0;
      range_err_q    <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      protocol_err_q <= accept && read && write;
      range_err_q    <= finish && !in_range;
      if (accept) begin
        addr_q     <= address;
        wdata_q    <= writedata;
        be_q       <= byteenable;
        op_write_q <= write && !read;
        cnt_q      <= load_val;
      end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (finish && !op_write_q) begin
        readdata_q <= in_range ? mem_q[mem_idx] : 32'd0;
      end
    end
  end

  // Byte-lane masked write at the end of the wait period; an aborting reset
  // has already forced the FSM out of BUSY, so no write happens.
  always_ff @(posedge clk) begin
    if (finish && op_write_q && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) mem_q[mem_idx][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign readdata     = readdata_q;
  assign range_err    = range_err_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_avalon_ram_model.sv
// Randomised self-checking bench for avalon_ram_model with a word-array
// reference model. Build with +define+RANDOM_WAIT_EN to exercise the
// pseudo-random wait-state mode.
module tb_avalon_ram_model;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int unsigned DEPTH = 16;
`ifdef RANDOM_WAIT_EN
  localparam int unsigned WAIT  = 3;
`else
  localparam int unsigned WAIT  = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address = '0;
  logic [3:0]  byteenable = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        range_err;
  logic        protocol_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_rd = '0;

  avalon_ram_model #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAIT), .RAM_INIT_FILE("")
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata),
    .range_err(range_err), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // One complete transfer; called at posedge+1, returns at posedge+1 of the
  // cycle after the acknowledge.
  task automatic xfer(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] rdata, output int lat,
                      output logic rerr, output logic perr1);
    read = r; write = w; address = a; writedata = d; byteenable = be;
    #1;
    check("wait_c0", waitrequest, 1'b1);
    lat = 0;
    perr1 = 1'b0;
    while (waitrequest && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) perr1 = protocol_err;
    end
    if (waitrequest) check("timeout", waitrequest, 1'b0);
    rdata = readdata;
    rerr  = range_err;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    check("err_clr", {range_err, protocol_err}, 2'b00);
  endtask

  // Transfer checked against the reference model.
  task automatic do_op(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, output int lat);
    logic [31:0] rdata;
    logic rerr, perr1;
    xfer(r, w, a, d, be, rdata, lat, rerr, perr1);
    if (r) begin
      last_rd = in_win(a) ? model_mem[widx(a)] : 32'd0;
    end else if (w && in_win(a)) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) model_mem[widx(a)][8*k +: 8] = d[8*k +: 8];
    end
    check("readdata", rdata, last_rd);
    check("range_err", rerr, !in_win(a));
    check("protocol_err", perr1, r & w);
`ifdef RANDOM_WAIT_EN
    check("lat_range", (lat >= 2 && lat <= int'(WAIT) + 2), 1'b1);
`else
    check("latency", lat, WAIT + 2);
`endif
    $display("%s a=%h d=%h be=%b rd=%h lat=%0d rerr=%b perr=%b",
             r ? (w ? "RW" : "RD") : "WR", a, d, be, rdata, lat, rerr, perr1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    last_rd = '0;
  endtask

  initial begin
    int lat;
    int n;
    logic [31:0] a;
    int sel;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;

    // Reset state, and waitrequest follows the IDLE equation during reset.
    #2;
    check("rst_wait", waitrequest, 1'b0);
    check("rst_rdata", readdata, 32'd0);
    check("rst_errs", {range_err, protocol_err}, 2'b00);
    read = 1'b1; #1;
    check("rst_wait_rd", waitrequest, 1'b1);
    read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed: first read, lane-merged write, out-of-window, read+write.
    do_op(1, 0, BASE, 0, 4'hF, lat);
    do_op(0, 1, BASE + 32'h10, 32'hDEADBEEF, 4'b1111, lat);
    do_op(0, 1, BASE + 32'h10, 32'h00000055, 4'b0001, lat);
    do_op(1, 0, BASE + 32'h10, 0, 4'h0, lat);
    check("merge", last_rd, 32'hDEADBE55);
    do_op(1, 0, 32'h00000000, 0, 4'h0, lat);
    do_op(1, 0, BASE + 4 * DEPTH, 0, 4'h0, lat);
    do_op(0, 1, BASE + 4 * DEPTH, 32'hFFFFFFFF, 4'hF, lat);
    do_op(0, 1, BASE - 4, 32'hFFFFFFFF, 4'hF, lat);
    do_op(0, 1, BASE + 32'h14, 32'hA5A5A5A5, 4'b0000, lat);
    do_op(1, 1, BASE + 32'h4, 32'h77777777, 4'hF, lat);
    for (int i = 0; i < int'(DEPTH); i++) do_op(1, 0, BASE + 4 * i, 0, 4'h0, lat);

    // Master drops the write and scribbles the bus while BUSY.
    read = 1'b0; write = 1'b1; address = BASE + 32'h8;
    writedata = 32'h12345678; byteenable = 4'hF;
    @(posedge clk); #1;
    write = 1'b0; writedata = '0; address = BASE + 32'h20; byteenable = '0;
    n = 0;
    while (waitrequest && n < 64) begin @(posedge clk); #1; n++; end
    check("drop_ack", waitrequest, 1'b0);
    @(posedge clk); #1;
    model_mem[2] = 32'h12345678;
    do_op(1, 0, BASE + 32'h8, 0, 4'h0, lat);
    check("drop_mem", last_rd, 32'h12345678);

    // Reset in the middle of a write aborts it.
    write = 1'b1; address = BASE + 32'hC; writedata = 32'hCAFEF00D; byteenable = 4'hF;
    @(posedge clk); #1;
    reset_n = 1'b0; #1;
    check("rst_busy_wr", waitrequest, 1'b1);
    write = 1'b0; #1;
    check("rst_busy_idle", waitrequest, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    last_rd = '0;
    @(posedge clk); #1;
    do_op(1, 0, BASE + 32'hC, 0, 4'h0, lat);

    // Randomised traffic against the model.
    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0) begin
        case ($urandom_range(0, 3))
          0: a = 32'h0;
          1: a = BASE - 32'($urandom_range(1, 64));
          2: a = BASE + 4 * DEPTH + 32'($urandom_range(0, 63));
          default: a = $urandom;
        endcase
      end else begin
        a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3);
      end
      sel = int'($urandom_range(0, 9));
      do_op(sel <= 3 || sel == 9, sel >= 4, a, $urandom, 4'($urandom), lat);
    end

`ifdef RANDOM_WAIT_EN
    // Wait-state sequence must repeat identically after each reset.
    begin
      int lat_a [8];
      pulse_reset();
      for (int i = 0; i < 8; i++) do_op(1, 0, BASE + 4 * i, 0, 4'h0, lat_a[i]);
      pulse_reset();
      for (int i = 0; i < 8; i++) begin
        do_op(1, 0, BASE + 4 * i, 0, 4'h0, lat);
        check("lfsr_repeat", lat, lat_a[i]);
      end
    end
`else
    pulse_reset();
    do_op(1, 0, BASE + 32'h10, 0, 4'h0, lat);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
